// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch stage. Holds the fetch PC and issues word requests to
// instruction memory. Returned words are buffered in a small queue and
// presented to decode as {Instr, PC, PCPlus4}. A redirect from execute flushes
// the queue and marks every in-flight response for discard.
//
// Handshakes (both channels): a transfer happens on a rising clock edge where
// valid && ready. Once raised, valid and its payload stay stable until the
// transfer happens, unless a redirect or reset abandons it. ready may depend
// combinationally on valid. The memory response channel has no ready: every
// response is taken, and responses come back in request order.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   imem_req_valid/ready/addr   memory request channel (word address)
//   imem_rsp_valid/data         in-order memory response
//   redirect, redirect_pc       flush and restart at redirect_pc (low bits cleared)
//   Instr, PC, PCPlus4          queue-head entry to decode
//   instr_valid/ready           decode handshake
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        instr_valid,
  input  logic        instr_ready
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t          DEPTH_C = cnt_t'(FIFO_DEPTH);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(FIFO_DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  cnt_t          outstanding;
  cnt_t          drop_cnt;
  cnt_t          count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   q_pc    [FIFO_DEPTH];
  logic [31:0]   q_instr [FIFO_DEPTH];

  logic          req_fire;
  logic          rsp_fire;
  logic          push;
  logic          pop;
  logic [CW:0]   committed;
  logic [31:0]   target;

  // committed = slots already spoken for: live (non-dropped) in-flight
  // responses plus words sitting in the queue. drop_cnt never exceeds
  // outstanding, so the subtraction cannot underflow.
  always_comb begin
    committed      = {1'b0, outstanding} - {1'b0, drop_cnt} + {1'b0, count};
    imem_req_valid = !reset && !redirect && (outstanding < DEPTH_C) &&
                     (committed < DEPTH_W);
    imem_req_addr  = fetch_pc;
    req_fire       = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    rsp_fire       = imem_rsp_valid && (outstanding != '0);
    push           = rsp_fire && (drop_cnt == '0);
    instr_valid    = (count != '0);
    pop            = instr_valid && instr_ready;
    target         = redirect_pc & ~32'h3;
  end

  // Head entry is shown even when the queue is empty; its contents only have
  // meaning while instr_valid is high.
  always_comb begin
    Instr   = q_instr[rd_ptr];
    PC      = q_pc[rd_ptr];
    PCPlus4 = q_pc[rd_ptr] + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        q_pc[i]    <= RESET_PC;
        q_instr[i] <= '0;
      end
    end else if (redirect) begin
      // Everything still in flight belongs to the wrong path, except a
      // response landing this very cycle, which is consumed and discarded now.
      fetch_pc    <= target;
      rsp_pc      <= target;
      outstanding <= outstanding - cnt_t'(rsp_fire);
      drop_cnt    <= outstanding - cnt_t'(rsp_fire);
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      outstanding <= outstanding + cnt_t'(req_fire) - cnt_t'(rsp_fire);
      if (rsp_fire && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - cnt_t'(1);
      end
      if (push) begin
        q_pc[wr_ptr]    <= rsp_pc;
        q_instr[wr_ptr] <= imem_rsp_data;
        wr_ptr          <= wr_ptr + AW'(1);
        rsp_pc          <= rsp_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      // Credit reserved a slot for every live response, so push into a
      // queue that is full before the pop cannot happen.
      count <= count + cnt_t'(push) - cnt_t'(pop);
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Directed vector table for reset, streaming, backpressure, redirect and
// wrap-around corners, then randomized traffic against an in-order memory
// model and a delivery scoreboard: every request accepted since the last
// redirect/reset must come out to decode once, in order, with the word the
// memory returned for that address.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          DEPTH  = 2;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        instr_valid;
  logic        instr_ready;

  instr_fetch #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .Instr          (Instr),
    .PC             (PC),
    .PCPlus4        (PCPlus4),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        rr;    // imem_req_ready
    logic        rv;    // imem_rsp_valid
    logic [31:0] d;     // imem_rsp_data
    logic        ir;    // instr_ready
    logic        rd;    // redirect
    logic [31:0] rpc;   // redirect_pc
    logic        erv;   // expected imem_req_valid
    logic [31:0] ea;    // expected imem_req_addr (when erv)
    logic        eiv;   // expected instr_valid
    logic [31:0] epc;   // expected PC (when eiv)
    logic [31:0] ei;    // expected Instr (when eiv)
  } vec_t;

  localparam int NV = 26;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic rr, input logic rv, input logic [31:0] d,
                              input logic ir, input logic rd, input logic [31:0] rpc,
                              input logic erv, input logic [31:0] ea,
                              input logic eiv, input logic [31:0] epc, input logic [31:0] ei);
    vec_t v;
    v.rr = rr; v.rv = rv; v.d = d; v.ir = ir; v.rd = rd; v.rpc = rpc;
    v.erv = erv; v.ea = ea; v.eiv = eiv; v.epc = epc; v.ei = ei;
    return v;
  endfunction

  task automatic fill_vectors();
    //                rr rv data          ir rd rpc             erv addr          eiv pc            instr
    // streaming fill, then decode stalls: only two requests go out
    vecs[0]  = mk(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h100,       0, 32'h0,        32'h0);
    vecs[1]  = mk(1, 1, 32'h00500093, 0, 0, 32'h0,        1, 32'h104,       0, 32'h0,        32'h0);
    vecs[2]  = mk(1, 1, 32'h00A00113, 0, 0, 32'h0,        0, 32'h0,         1, 32'h100,      32'h00500093);
    vecs[3]  = mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,         1, 32'h100,      32'h00500093);
    vecs[4]  = mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,         1, 32'h100,      32'h00500093);
    // decode resumes: no lost or duplicated PCs
    vecs[5]  = mk(1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,         1, 32'h100,      32'h00500093);
    vecs[6]  = mk(1, 0, 32'h0,        1, 0, 32'h0,        1, 32'h108,       1, 32'h104,      32'h00A00113);
    vecs[7]  = mk(1, 1, 32'h00308193, 1, 0, 32'h0,        1, 32'h10C,       0, 32'h0,        32'h0);
    vecs[8]  = mk(1, 1, 32'h00418213, 1, 0, 32'h0,        0, 32'h0,         1, 32'h108,      32'h00308193);
    vecs[9]  = mk(1, 0, 32'h0,        1, 0, 32'h0,        1, 32'h110,       1, 32'h10C,      32'h00418213);
    vecs[10] = mk(1, 0, 32'h0,        1, 0, 32'h0,        1, 32'h114,       0, 32'h0,        32'h0);
    // redirect with two in flight, no response that cycle
    vecs[11] = mk(1, 0, 32'h0,        1, 1, 32'h00002003, 0, 32'h0,         0, 32'h0,        32'h0);
    vecs[12] = mk(1, 1, 32'hDEAD0001, 1, 0, 32'h0,        0, 32'h0,         0, 32'h0,        32'h0);
    vecs[13] = mk(1, 1, 32'hDEAD0002, 1, 0, 32'h0,        1, 32'h2000,      0, 32'h0,        32'h0);
    vecs[14] = mk(0, 1, 32'h11111111, 1, 0, 32'h0,        1, 32'h2004,      0, 32'h0,        32'h0);
    vecs[15] = mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h2004,      1, 32'h2000,     32'h11111111);
    vecs[16] = mk(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h2004,      0, 32'h0,        32'h0);
    vecs[17] = mk(0, 1, 32'h22222222, 0, 0, 32'h0,        1, 32'h2008,      0, 32'h0,        32'h0);
    vecs[18] = mk(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h2008,      1, 32'h2004,     32'h22222222);
    // redirect coincident with response and pop, one outstanding; wrap target
    vecs[19] = mk(1, 1, 32'h33333333, 1, 1, 32'hFFFFFFFE, 0, 32'h0,         1, 32'h2004,     32'h22222222);
    vecs[20] = mk(1, 0, 32'h0,        1, 0, 32'h0,        1, 32'hFFFFFFFC,  0, 32'h0,        32'h0);
    vecs[21] = mk(1, 1, 32'h44444444, 1, 0, 32'h0,        1, 32'h0,         0, 32'h0,        32'h0);
    vecs[22] = mk(0, 1, 32'h55555555, 1, 0, 32'h0,        0, 32'h0,         1, 32'hFFFFFFFC, 32'h44444444);
    vecs[23] = mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h4,         1, 32'h0,        32'h55555555);
    // response with nothing outstanding is ignored
    vecs[24] = mk(0, 1, 32'h66666666, 1, 0, 32'h0,        1, 32'h4,         0, 32'h0,        32'h0);
    vecs[25] = mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h4,         0, 32'h0,        32'h0);
  endtask

  // ---------------- reference model state ----------------
  logic [31:0] pend_q[$];   // addresses the memory still owes a response for
  logic [31:0] exp_q[$];    // PCs decode must still receive, in order
  logic [31:0] exp_fetch;   // address the next request must carry
  bit          after_flush; // previous cycle was a redirect or reset
  bit          drain;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect       = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset          = 1'b1;
    imem_req_ready = 1'($urandom);
    imem_rsp_valid = 1'($urandom);
    imem_rsp_data  = $urandom;
    instr_ready    = 1'($urandom);
    redirect       = 1'b0;
    repeat (cycles) @(negedge clk);
    #1;
    check("rst.req_valid",   imem_req_valid, 0);
    check("rst.instr_valid", instr_valid,    0);
    check("rst.pc",          PC,             RST_PC);
    check("rst.pcplus4",     PCPlus4,        RST_PC + 32'd4);
    check("rst.instr",       Instr,          32'h0);
    idle_inputs();
    reset = 1'b0;
    pend_q.delete();
    exp_q.delete();
    exp_fetch   = RST_PC;
    after_flush = 1'b1;
  endtask

  task automatic apply_vectors();
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      imem_req_ready = vecs[i].rr;
      imem_rsp_valid = vecs[i].rv;
      imem_rsp_data  = vecs[i].d;
      instr_ready    = vecs[i].ir;
      redirect       = vecs[i].rd;
      redirect_pc    = vecs[i].rpc;
      #1;
      check($sformatf("v%0d.req_valid", i), imem_req_valid, vecs[i].erv);
      if (vecs[i].erv) check($sformatf("v%0d.req_addr", i), imem_req_addr, vecs[i].ea);
      check($sformatf("v%0d.instr_valid", i), instr_valid, vecs[i].eiv);
      if (vecs[i].eiv) begin
        check($sformatf("v%0d.pc", i),      PC,      vecs[i].epc);
        check($sformatf("v%0d.instr", i),   Instr,   vecs[i].ei);
        check($sformatf("v%0d.pcplus4", i), PCPlus4, vecs[i].epc + 32'd4);
      end
    end
    idle_inputs();
  endtask

  task automatic rand_cycle(input bit allow_new);
    logic        fire_req;
    logic        fire_pop;
    logic [31:0] exp_pc;
    @(negedge clk);
    imem_req_ready = allow_new && ($urandom_range(0, 3) != 0);
    instr_ready    = drain || ($urandom_range(0, 2) != 0);
    redirect       = allow_new && ($urandom_range(0, 15) == 0);
    redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                 : $urandom;
    if (pend_q.size() != 0) begin
      imem_rsp_valid = drain || ($urandom_range(0, 4) >= 2);
      imem_rsp_data  = mem_word(pend_q[0]);
    end else begin
      imem_rsp_valid = !drain && ($urandom_range(0, 15) == 0);
      imem_rsp_data  = $urandom;
    end
    #1;
    if (redirect)       check("no_req_on_redirect", imem_req_valid, 0);
    if (imem_req_valid) check("req_addr", imem_req_addr, exp_fetch);
    if (after_flush)    check("flushed_empty", instr_valid, 0);
    if (instr_valid)    check("pcplus4", PCPlus4, PC + 32'd4);
    fire_req = imem_req_valid && imem_req_ready;
    fire_pop = instr_valid && instr_ready && !redirect;
    if (fire_req) check("inflight_limit", pend_q.size() < DEPTH, 1);
    if (fire_pop) begin
      check("deliver_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        exp_pc = exp_q.pop_front();
        check("deliver_pc",    PC,    exp_pc);
        check("deliver_instr", Instr, mem_word(exp_pc));
        n_pops++;
      end
    end
    // model update for the coming edge
    if (imem_rsp_valid && pend_q.size() != 0) void'(pend_q.pop_front());
    if (fire_req) begin
      pend_q.push_back(imem_req_addr);
      exp_q.push_back(exp_fetch);
      exp_fetch = exp_fetch + 32'd4;
    end
    if (redirect) begin
      exp_fetch = redirect_pc & ~32'h3;
      exp_q.delete();
    end
    after_flush = redirect;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    idle_inputs();
    drain       = 1'b0;
    after_flush = 1'b0;
    exp_fetch   = RST_PC;
    fill_vectors();

    do_reset(2);
    apply_vectors();

    do_reset(1);
    for (int i = 0; i < 2500; i++) rand_cycle(1'b1);
    // reset in the middle of traffic abandons everything in flight
    do_reset(1);
    for (int i = 0; i < 2500; i++) rand_cycle(1'b1);

    drain = 1'b1;
    for (int i = 0; i < 40; i++) rand_cycle(1'b0);
    #1;
    check("drain_all_delivered", exp_q.size(), 0);
    check("drain_queue_empty",   instr_valid,  0);
    check("progress",            n_pops > 200, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
